// File: rtl/bp_me_cache_dma_arbiter.sv
// Shares one BedRock DMA memory channel among several L2 cache slices: round-robin
// command arbitration, write-burst locking, and in-order response steering by tag FIFO.
module bp_me_cache_dma_arbiter #(
  parameter int num_slices_p      = 4,
  parameter int paddr_width_p     = 40,
  parameter int header_width_p    = 64,
  parameter int data_width_p      = 64,
  parameter int block_width_p     = 512,
  parameter int max_outstanding_p = 4,
  parameter int msg_type_lsb_p    = 0,
  parameter int msg_type_width_p  = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,

  input  logic [num_slices_p*header_width_p-1:0]     slice_cmd_header_i,
  input  logic [num_slices_p-1:0]                    slice_cmd_header_v_i,
  output logic [num_slices_p-1:0]                    slice_cmd_header_yumi_o,
  input  logic [num_slices_p*data_width_p-1:0]       slice_cmd_data_i,
  input  logic [num_slices_p-1:0]                    slice_cmd_data_v_i,
  output logic [num_slices_p-1:0]                    slice_cmd_data_yumi_o,

  output logic [header_width_p-1:0]                  slice_resp_header_o,
  output logic [num_slices_p-1:0]                    slice_resp_header_v_o,
  input  logic [num_slices_p-1:0]                    slice_resp_header_ready_i,
  output logic [data_width_p-1:0]                    slice_resp_data_o,
  output logic [num_slices_p-1:0]                    slice_resp_data_v_o,
  input  logic [num_slices_p-1:0]                    slice_resp_data_ready_i,

  output logic [header_width_p-1:0]                  mem_cmd_header_o,
  output logic                                       mem_cmd_header_v_o,
  input  logic                                       mem_cmd_header_yumi_i,
  output logic [data_width_p-1:0]                    mem_cmd_data_o,
  output logic                                       mem_cmd_data_v_o,
  input  logic                                       mem_cmd_data_yumi_i,

  input  logic [header_width_p-1:0]                  mem_resp_header_i,
  input  logic                                       mem_resp_header_v_i,
  output logic                                       mem_resp_header_ready_o,
  input  logic [data_width_p-1:0]                    mem_resp_data_i,
  input  logic                                       mem_resp_data_v_i,
  output logic                                       mem_resp_data_ready_o,

  output logic                                       debug_cmd_state_o,
  output logic                                       debug_resp_state_o,
  output logic [$clog2(num_slices_p)-1:0]            debug_rr_ptr_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]     debug_fifo_count_o
);

  // Handshakes: a transfer happens in any cycle where valid and ready (or valid and
  // yumi) are both high; valid never depends on ready, yumi is only raised with valid.

  localparam int sw    = $clog2(num_slices_p);
  localparam int beats = block_width_p / data_width_p;
  localparam int bw    = (beats > 1) ? $clog2(beats) : 1;
  localparam int pw    = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cw    = $clog2(max_outstanding_p + 1);
  localparam logic [bw-1:0] last_beat = bw'(beats - 1);
  localparam logic [msg_type_width_p-1:0] mem_wr_type = msg_type_width_p'(1);

  if (num_slices_p < 2 || paddr_width_p < 1
      || header_width_p < msg_type_lsb_p + msg_type_width_p) begin : g_bad_params
    $error("bp_me_cache_dma_arbiter: illegal parameter combination");
  end

  typedef enum logic {e_ready, e_wr_data} cmd_state_e;
  typedef enum logic {e_resp_header, e_resp_data} resp_state_e;

  cmd_state_e  cmd_state_r, cmd_state_n;
  resp_state_e resp_state_r, resp_state_n;

  logic [sw-1:0] rr_ptr_r, wr_owner_r, winner;
  logic [bw-1:0] cmd_beat_r, resp_beat_r;
  logic          req_found, is_read;
  logic [header_width_p-1:0] win_header;
  logic [data_width_p-1:0]   owner_data;
  logic          owner_data_v;
  logic          cmd_header_v, cmd_data_v, data_hs, push, pop;

  logic [sw:0]   tag_mem [max_outstanding_p];
  logic [pw-1:0] wptr_r, rptr_r;
  logic [cw-1:0] count_r;
  logic          fifo_full, fifo_empty;
  logic [sw:0]   head_tag;
  logic [sw-1:0] head_slice;
  logic          head_is_read, resp_live;
  logic          resp_header_ready, resp_data_ready;
  logic [num_slices_p-1:0] header_yumi, data_yumi, resp_header_v, resp_data_v;

  assign fifo_full  = (count_r == cw'(max_outstanding_p));
  assign fifo_empty = (count_r == '0);

  // First requester at or after rr_ptr, scanning with wraparound.
  always_comb begin : arb_sel
    int c;
    req_found = 1'b0;
    winner    = '0;
    c         = 0;
    for (int i = 0; i < num_slices_p; i++) begin
      c = int'(rr_ptr_r) + i;
      if (c >= num_slices_p) c = c - num_slices_p;
      if (!req_found && slice_cmd_header_v_i[sw'(c)]) begin
        req_found = 1'b1;
        winner    = sw'(c);
      end
    end
  end

  always_comb begin
    win_header   = '0;
    owner_data   = '0;
    owner_data_v = 1'b0;
    for (int i = 0; i < num_slices_p; i++) begin
      if (winner == sw'(i))
        win_header = slice_cmd_header_i[i*header_width_p +: header_width_p];
      if (wr_owner_r == sw'(i)) begin
        owner_data   = slice_cmd_data_i[i*data_width_p +: data_width_p];
        owner_data_v = slice_cmd_data_v_i[i];
      end
    end
  end

  assign is_read = (win_header[msg_type_lsb_p +: msg_type_width_p] != mem_wr_type);

  always_comb begin
    cmd_state_n  = cmd_state_r;
    cmd_header_v = 1'b0;
    cmd_data_v   = 1'b0;
    data_hs      = 1'b0;
    push         = 1'b0;
    header_yumi  = '0;
    data_yumi    = '0;
    case (cmd_state_r)
      e_ready: begin
        cmd_header_v = reset_n_i & req_found & ~fifo_full;
        if (cmd_header_v && mem_cmd_header_yumi_i) begin
          push                = 1'b1;
          header_yumi[winner] = 1'b1;
          if (!is_read) cmd_state_n = e_wr_data;
        end
      end
      e_wr_data: begin
        cmd_data_v = reset_n_i & owner_data_v;
        if (cmd_data_v && mem_cmd_data_yumi_i) begin
          data_hs               = 1'b1;
          data_yumi[wr_owner_r] = 1'b1;
          if (cmd_beat_r == last_beat) cmd_state_n = e_ready;
        end
      end
      default: cmd_state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_state_r <= e_ready;
      rr_ptr_r    <= '0;
      wr_owner_r  <= '0;
      cmd_beat_r  <= '0;
    end else begin
      cmd_state_r <= cmd_state_n;
      if (push) begin
        rr_ptr_r <= (winner == sw'(num_slices_p - 1)) ? '0 : winner + 1'b1;
        if (!is_read) begin
          wr_owner_r <= winner;
          cmd_beat_r <= '0;
        end
      end else if (data_hs) begin
        cmd_beat_r <= (cmd_beat_r == last_beat) ? '0 : cmd_beat_r + 1'b1;
      end
    end
  end

  // Tag FIFO head decides which slice owns the current in-order memory response.
  assign head_tag     = tag_mem[rptr_r];
  assign head_slice   = head_tag[sw:1];
  assign head_is_read = head_tag[0];
  assign resp_live    = reset_n_i & ~fifo_empty;

  always_comb begin
    resp_state_n      = resp_state_r;
    resp_header_v     = '0;
    resp_data_v       = '0;
    resp_header_ready = 1'b0;
    resp_data_ready   = 1'b0;
    pop               = 1'b0;
    case (resp_state_r)
      e_resp_header: if (resp_live) begin
        resp_header_v[head_slice] = mem_resp_header_v_i;
        resp_header_ready         = slice_resp_header_ready_i[head_slice];
        if (resp_header_ready && mem_resp_header_v_i) begin
          if (head_is_read) resp_state_n = e_resp_data;
          else              pop          = 1'b1;
        end
      end
      e_resp_data: if (resp_live) begin
        resp_data_v[head_slice] = mem_resp_data_v_i;
        resp_data_ready         = slice_resp_data_ready_i[head_slice];
        if (resp_data_ready && mem_resp_data_v_i && resp_beat_r == last_beat) begin
          pop          = 1'b1;
          resp_state_n = e_resp_header;
        end
      end
      default: resp_state_n = e_resp_header;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_state_r <= e_resp_header;
      resp_beat_r  <= '0;
    end else begin
      resp_state_r <= resp_state_n;
      if (resp_state_r == e_resp_header)
        resp_beat_r <= '0;
      else if (resp_data_ready && mem_resp_data_v_i)
        resp_beat_r <= (resp_beat_r == last_beat) ? '0 : resp_beat_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= (wptr_r == pw'(max_outstanding_p - 1)) ? '0 : wptr_r + 1'b1;
      if (pop)  rptr_r <= (rptr_r == pw'(max_outstanding_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wptr_r] <= {winner, is_read};
  end

  assign mem_cmd_header_o        = win_header;
  assign mem_cmd_header_v_o      = cmd_header_v;
  assign mem_cmd_data_o          = owner_data;
  assign mem_cmd_data_v_o        = cmd_data_v;
  assign slice_cmd_header_yumi_o = header_yumi;
  assign slice_cmd_data_yumi_o   = data_yumi;

  assign slice_resp_header_o     = mem_resp_header_i;
  assign slice_resp_header_v_o   = resp_header_v;
  assign slice_resp_data_o       = mem_resp_data_i;
  assign slice_resp_data_v_o     = resp_data_v;
  assign mem_resp_header_ready_o = resp_header_ready;
  assign mem_resp_data_ready_o   = resp_data_ready;

  assign debug_cmd_state_o  = cmd_state_r;
  assign debug_resp_state_o = resp_state_r;
  assign debug_rr_ptr_o     = rr_ptr_r;
  assign debug_fifo_count_o = count_r;

endmodule

// File: tb/tb_bp_me_cache_dma_arbiter.sv
// Directed bench for bp_me_cache_dma_arbiter: arbitration vector table plus
// hand-written write-burst, FIFO-full, response-steering and reset sequences.
module tb_bp_me_cache_dma_arbiter;

  localparam int N  = 4;
  localparam int HW = 64;
  localparam int DW = 64;
  localparam int B  = 512 / DW;
  localparam int D  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk = ~clk;

  logic [N*HW-1:0] slice_cmd_header_i = '0;
  logic [N-1:0]    slice_cmd_header_v_i = '0;
  logic [N-1:0]    slice_cmd_header_yumi_o;
  logic [N*DW-1:0] slice_cmd_data_i = '0;
  logic [N-1:0]    slice_cmd_data_v_i = '0;
  logic [N-1:0]    slice_cmd_data_yumi_o;
  logic [HW-1:0]   slice_resp_header_o;
  logic [N-1:0]    slice_resp_header_v_o;
  logic [N-1:0]    slice_resp_header_ready_i = '1;
  logic [DW-1:0]   slice_resp_data_o;
  logic [N-1:0]    slice_resp_data_v_o;
  logic [N-1:0]    slice_resp_data_ready_i = '1;
  logic [HW-1:0]   mem_cmd_header_o;
  logic            mem_cmd_header_v_o;
  logic            mem_cmd_header_yumi_i = 1'b0;
  logic [DW-1:0]   mem_cmd_data_o;
  logic            mem_cmd_data_v_o;
  logic            mem_cmd_data_yumi_i = 1'b0;
  logic [HW-1:0]   mem_resp_header_i = '0;
  logic            mem_resp_header_v_i = 1'b0;
  logic            mem_resp_header_ready_o;
  logic [DW-1:0]   mem_resp_data_i = '0;
  logic            mem_resp_data_v_i = 1'b0;
  logic            mem_resp_data_ready_o;
  logic            debug_cmd_state_o;
  logic            debug_resp_state_o;
  logic [1:0]      debug_rr_ptr_o;
  logic [2:0]      debug_fifo_count_o;

  bp_me_cache_dma_arbiter #(
    .num_slices_p(N), .paddr_width_p(40), .header_width_p(HW), .data_width_p(DW),
    .block_width_p(512), .max_outstanding_p(D)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .slice_cmd_header_i(slice_cmd_header_i), .slice_cmd_header_v_i(slice_cmd_header_v_i),
    .slice_cmd_header_yumi_o(slice_cmd_header_yumi_o),
    .slice_cmd_data_i(slice_cmd_data_i), .slice_cmd_data_v_i(slice_cmd_data_v_i),
    .slice_cmd_data_yumi_o(slice_cmd_data_yumi_o),
    .slice_resp_header_o(slice_resp_header_o), .slice_resp_header_v_o(slice_resp_header_v_o),
    .slice_resp_header_ready_i(slice_resp_header_ready_i),
    .slice_resp_data_o(slice_resp_data_o), .slice_resp_data_v_o(slice_resp_data_v_o),
    .slice_resp_data_ready_i(slice_resp_data_ready_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
    .mem_cmd_header_yumi_i(mem_cmd_header_yumi_i),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_data_yumi_i(mem_cmd_data_yumi_i),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i),
    .mem_resp_header_ready_o(mem_resp_header_ready_o),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
    .mem_resp_data_ready_o(mem_resp_data_ready_o),
    .debug_cmd_state_o(debug_cmd_state_o), .debug_resp_state_o(debug_resp_state_o),
    .debug_rr_ptr_o(debug_rr_ptr_o), .debug_fifo_count_o(debug_fifo_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] hdr(input int s, input bit wr);
    return 64'hABCD_0000_0000_0000 | (64'(s) << 16) | 64'(wr);
  endfunction

  function automatic logic [63:0] wdata(input int s, input int k);
    return 64'hD000_0000_0000_0000 | (64'(s) << 8) | 64'(k);
  endfunction

  function automatic logic [63:0] rdata(input int k);
    return 64'h5500_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [3:0] onehot(input int s);
    return 4'b0001 << s;
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input bit v, input bit wr);
    slice_cmd_header_i[s*HW +: HW] = hdr(s, wr);
    slice_cmd_header_v_i[s] = v;
  endtask

  task automatic set_data(input int s, input logic [63:0] d, input bit v);
    slice_cmd_data_i[s*DW +: DW] = d;
    slice_cmd_data_v_i[s] = v;
  endtask

  task automatic deliver_read(input int s, input int stall, input bit chk_blocked);
    mem_resp_header_i   = 64'h7777_0000_0000_0000 | 64'(s);
    mem_resp_header_v_i = 1'b1;
    #1;
    check("rd_resp_hdr_v", 64'(slice_resp_header_v_o), 64'(onehot(s)));
    check("rd_resp_hdr_ready", 64'(mem_resp_header_ready_o), 64'd1);
    check("rd_resp_hdr_bcast", slice_resp_header_o, mem_resp_header_i);
    check("rd_resp_hdr_phase_data_ready", 64'(mem_resp_data_ready_o), 64'd0);
    tick;
    mem_resp_header_v_i = 1'b0;
    for (int k = 0; k < B; k++) begin
      mem_resp_data_i   = rdata(k);
      mem_resp_data_v_i = 1'b1;
      if (k == 2) begin
        for (int st = 0; st < stall; st++) begin
          slice_resp_data_ready_i = ~onehot(s);
          #1;
          check("rd_stall_ready", 64'(mem_resp_data_ready_o), 64'd0);
          check("rd_stall_v", 64'(slice_resp_data_v_o), 64'(onehot(s)));
          tick;
        end
        slice_resp_data_ready_i = '1;
      end
      #1;
      check("rd_beat_v", 64'(slice_resp_data_v_o), 64'(onehot(s)));
      check("rd_beat_data", slice_resp_data_o, rdata(k));
      check("rd_beat_ready", 64'(mem_resp_data_ready_o), 64'd1);
      if (chk_blocked) check("full_blocks_hdr", 64'(mem_cmd_header_v_o), 64'd0);
      tick;
    end
    mem_resp_data_v_i = 1'b0;
  endtask

  task automatic deliver_write_resp(input int s);
    mem_resp_header_i   = 64'h6666_0000_0000_0000 | 64'(s);
    mem_resp_header_v_i = 1'b1;
    #1;
    check("wr_resp_hdr_v", 64'(slice_resp_header_v_o), 64'(onehot(s)));
    check("wr_resp_hdr_ready", 64'(mem_resp_header_ready_o), 64'd1);
    tick;
    mem_resp_header_v_i = 1'b0;
  endtask

  // scoreboard: every memory-side command handshake must match the expected queue
  task automatic sb_check(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=%h required=no transfer", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (mem_cmd_header_v_o && mem_cmd_header_yumi_i) sb_check("sb_mem_cmd_header", mem_cmd_header_o);
    if (mem_cmd_data_v_o && mem_cmd_data_yumi_i)     sb_check("sb_mem_cmd_data", mem_cmd_data_o);
  end

  typedef struct {
    logic [3:0] req;
    logic       exp_v;
    int         exp_win;
  } arb_vec_t;

  arb_vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b0000, 1'b0, 0};
    vecs[1] = '{4'b0001, 1'b1, 0};
    vecs[2] = '{4'b0100, 1'b1, 2};
    vecs[3] = '{4'b1010, 1'b1, 1};
    vecs[4] = '{4'b1000, 1'b1, 3};
    vecs[5] = '{4'b1111, 1'b1, 0};
    vecs[6] = '{4'b1100, 1'b1, 2};

    // reset: outputs gated even with every input valid asserted
    for (int s = 0; s < N; s++) begin
      set_req(s, 1'b1, 1'b0);
      set_data(s, wdata(s, 0), 1'b1);
    end
    mem_resp_header_v_i   = 1'b1;
    mem_resp_data_v_i     = 1'b1;
    mem_cmd_header_yumi_i = 1'b1;
    mem_cmd_data_yumi_i   = 1'b1;
    repeat (2) tick;
    check("rst_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
    check("rst_hdr_yumi", 64'(slice_cmd_header_yumi_o), 64'd0);
    check("rst_data_v", 64'(mem_cmd_data_v_o), 64'd0);
    check("rst_data_yumi", 64'(slice_cmd_data_yumi_o), 64'd0);
    check("rst_resp_hdr_ready", 64'(mem_resp_header_ready_o), 64'd0);
    check("rst_resp_data_ready", 64'(mem_resp_data_ready_o), 64'd0);
    check("rst_resp_hdr_v", 64'(slice_resp_header_v_o), 64'd0);
    check("rst_resp_data_v", 64'(slice_resp_data_v_o), 64'd0);
    check("rst_state", 64'(debug_cmd_state_o), 64'd0);
    check("rst_rr", 64'(debug_rr_ptr_o), 64'd0);
    check("rst_count", 64'(debug_fifo_count_o), 64'd0);
    slice_cmd_header_v_i  = '0;
    slice_cmd_data_v_i    = '0;
    mem_resp_header_v_i   = 1'b0;
    mem_resp_data_v_i     = 1'b0;
    mem_cmd_header_yumi_i = 1'b0;
    mem_cmd_data_yumi_i   = 1'b0;
    reset_n_i = 1'b1;
    tick;

    // arbitration table at rr_ptr = 0, no consumption
    for (int i = 0; i < 7; i++) begin
      for (int s = 0; s < N; s++) set_req(s, vecs[i].req[s], 1'b0);
      #1;
      check("tbl_hdr_v", 64'(mem_cmd_header_v_o), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) check("tbl_hdr", mem_cmd_header_o, hdr(vecs[i].exp_win, 1'b0));
      check("tbl_no_yumi", 64'(slice_cmd_header_yumi_o), 64'd0);
      tick;
    end
    slice_cmd_header_v_i = '0;

    // slices 0 and 2 read together: back-to-back grants
    mem_cmd_header_yumi_i = 1'b1;
    mem_cmd_data_yumi_i   = 1'b1;
    set_req(0, 1'b1, 1'b0);
    set_req(2, 1'b1, 1'b0);
    exp_q.push_back(hdr(0, 1'b0));
    exp_q.push_back(hdr(2, 1'b0));
    #1;
    check("rd01_hdr", mem_cmd_header_o, hdr(0, 1'b0));
    check("rd01_yumi", 64'(slice_cmd_header_yumi_o), 64'(4'b0001));
    tick;
    set_req(0, 1'b0, 1'b0);
    #1;
    check("rd02_hdr", mem_cmd_header_o, hdr(2, 1'b0));
    check("rd02_yumi", 64'(slice_cmd_header_yumi_o), 64'(4'b0100));
    tick;
    set_req(2, 1'b0, 1'b0);
    #1;
    check("rd0x_idle", 64'(mem_cmd_header_v_o), 64'd0);
    check("rd0x_rr", 64'(debug_rr_ptr_o), 64'd3);
    check("rd0x_count", 64'(debug_fifo_count_o), 64'd2);
    deliver_read(0, 0, 1'b0);
    deliver_read(2, 0, 1'b0);
    check("rd0x_drained", 64'(debug_fifo_count_o), 64'd0);

    // slice 1 write burst, slice 3 read raised mid-burst
    set_req(1, 1'b1, 1'b1);
    exp_q.push_back(hdr(1, 1'b1));
    for (int k = 0; k < B; k++) exp_q.push_back(wdata(1, k));
    #1;
    check("wr_hdr", mem_cmd_header_o, hdr(1, 1'b1));
    tick;
    set_req(1, 1'b0, 1'b1);
    for (int k = 0; k < B; k++) begin
      set_data(1, wdata(1, k), 1'b1);
      set_data(0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
      if (k == 3) set_req(3, 1'b1, 1'b0);
      if (k == 5) begin
        mem_cmd_data_yumi_i = 1'b0;
        #1;
        check("wr_hold_yumi", 64'(slice_cmd_data_yumi_o), 64'd0);
        check("wr_hold_v", 64'(mem_cmd_data_v_o), 64'd1);
        tick;
        mem_cmd_data_yumi_i = 1'b1;
      end
      #1;
      check("wr_beat_data", mem_cmd_data_o, wdata(1, k));
      check("wr_beat_yumi", 64'(slice_cmd_data_yumi_o), 64'(4'b0010));
      if (k >= 3) check("wr_blocks_hdr", 64'(mem_cmd_header_v_o), 64'd0);
      tick;
    end
    slice_cmd_data_v_i = '0;
    exp_q.push_back(hdr(3, 1'b0));
    #1;
    check("post_wr_hdr_v", 64'(mem_cmd_header_v_o), 64'd1);
    check("post_wr_hdr", mem_cmd_header_o, hdr(3, 1'b0));
    tick;
    set_req(3, 1'b0, 1'b0);
    #1;
    check("post_wr_rr", 64'(debug_rr_ptr_o), 64'd0);
    check("post_wr_count", 64'(debug_fifo_count_o), 64'd2);
    deliver_write_resp(1);
    deliver_read(3, 0, 1'b0);

    // fill the tag FIFO, fifth request waits for the first read response to finish
    for (int s = 0; s < N; s++) begin
      set_req(s, 1'b1, 1'b0);
      exp_q.push_back(hdr(s, 1'b0));
    end
    for (int s = 0; s < N; s++) begin
      #1;
      check("full_fill_hdr", mem_cmd_header_o, hdr(s, 1'b0));
      tick;
      set_req(s, 1'b0, 1'b0);
    end
    set_req(0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("full_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
      check("full_count", 64'(debug_fifo_count_o), 64'd4);
      tick;
    end
    exp_q.push_back(hdr(0, 1'b0));
    deliver_read(0, 0, 1'b1);
    check("full_release_v", 64'(mem_cmd_header_v_o), 64'd1);
    check("full_release_hdr", mem_cmd_header_o, hdr(0, 1'b0));
    tick;
    set_req(0, 1'b0, 1'b0);
    deliver_read(1, 0, 1'b0);
    deliver_read(2, 3, 1'b0);
    deliver_read(3, 0, 1'b0);
    deliver_read(0, 0, 1'b0);
    check("full_drained", 64'(debug_fifo_count_o), 64'd0);

    // unsolicited response stalls
    mem_resp_header_v_i = 1'b1;
    mem_resp_data_v_i   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("unsol_hdr_ready", 64'(mem_resp_header_ready_o), 64'd0);
      check("unsol_data_ready", 64'(mem_resp_data_ready_o), 64'd0);
      check("unsol_hdr_v", 64'(slice_resp_header_v_o), 64'd0);
      tick;
    end
    mem_resp_header_v_i = 1'b0;
    mem_resp_data_v_i   = 1'b0;

    // reset at beat 3 of a slice 1 write
    set_req(1, 1'b1, 1'b1);
    exp_q.push_back(hdr(1, 1'b1));
    for (int k = 0; k < 3; k++) exp_q.push_back(wdata(1, k));
    #1;
    check("rstw_hdr", mem_cmd_header_o, hdr(1, 1'b1));
    tick;
    set_req(1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_data(1, wdata(1, k), 1'b1);
      #1;
      check("rstw_beat", mem_cmd_data_o, wdata(1, k));
      tick;
    end
    set_data(1, wdata(1, 3), 1'b1);
    set_req(0, 1'b1, 1'b0);
    set_req(2, 1'b1, 1'b0);
    reset_n_i = 1'b0;
    #1;
    check("rstw_data_v", 64'(mem_cmd_data_v_o), 64'd0);
    check("rstw_data_yumi", 64'(slice_cmd_data_yumi_o), 64'd0);
    check("rstw_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
    check("rstw_hdr_yumi", 64'(slice_cmd_header_yumi_o), 64'd0);
    tick;
    tick;
    reset_n_i = 1'b1;
    slice_cmd_data_v_i = '0;
    exp_q.push_back(hdr(0, 1'b0));
    exp_q.push_back(hdr(2, 1'b0));
    #1;
    check("rstw_state", 64'(debug_cmd_state_o), 64'd0);
    check("rstw_count", 64'(debug_fifo_count_o), 64'd0);
    check("rstw_rr", 64'(debug_rr_ptr_o), 64'd0);
    check("rstw_first_hdr", mem_cmd_header_o, hdr(0, 1'b0));
    tick;
    set_req(0, 1'b0, 1'b0);
    #1;
    check("rstw_second_hdr", mem_cmd_header_o, hdr(2, 1'b0));
    tick;
    set_req(2, 1'b0, 1'b0);
    deliver_read(0, 0, 1'b0);
    deliver_read(2, 0, 1'b0);
    tick;
    check("sb_all_transfers_seen", 64'(exp_q.size()), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
